// File: rtl/pc_fetch_redirect.sv
// rtl/pc_fetch_redirect.sv - fetch PC sequencer with branch redirect, stall skid buffer and IF/ID register
//
// Purpose: keeps the fetch PC, issues one instruction-memory request at a time,
// loads the IF/ID pipeline register, and handles hazard stalls and branch
// redirects. A response that lands while stalled goes into a one-entry skid
// buffer. A request that a redirect has squashed is drained in SQUASH so that
// its late response is never used.
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   defined   - the redirect target is forced to word alignment, and
//               Misaligned pulses for one cycle after each misaligned redirect.
//   undefined - the redirect target is used as given, and Misaligned is tied low.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   PcSel      in   redirect request from the branch unit
//   BrPC       in   redirect target (low PC_W bits used)
//   Stall      in   hazard stall, holds IF/ID
//   imem_req   out  fetch request level, held until imem_valid
//   imem_addr  out  fetch address (the PC register)
//   imem_valid in   one-cycle response strobe
//   imem_rdata in   instruction word, valid with imem_valid
//   IfId_PC    out  IF/ID captured PC
//   IfId_Instr out  IF/ID captured instruction (NOP when invalid)
//   IfId_Valid out  IF/ID valid
//   Flush      out  combinational squash of IF/ID and ID/EX (equals PcSel)
//   Misaligned out  registered one-cycle misaligned-redirect pulse
module pc_fetch_redirect #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Flush,
  output logic            Misaligned
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_HOLD   = 2'd2,
    S_SQUASH = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;
  logic [31:0]     r_skid;
  logic            r_skid_valid;

  logic            w_redirect;
  logic            w_accept;
  logic            w_capture;
  logic            w_release;

  // Only the low PC_W bits of the target address the instruction memory.
  logic            w_unused_brpc;
  assign w_unused_brpc = ^BrPC[31:PC_W];

  assign w_pc_inc = r_pc + PC_W'(4);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // A redirect with the old request still in flight must drain it in SQUASH.
        if (PcSel) begin
          w_state_nxt = imem_valid ? S_REQ : S_SQUASH;
        end else if (imem_valid && Stall) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PcSel || !Stall) begin
          w_state_nxt = S_REQ;
        end
      end
      S_SQUASH: begin
        // Leaving SQUASH does not depend on Stall. The discarded strobe lasts
        // one cycle, and waiting past it would never end.
        if (imem_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and datapath-control logic
  always_comb begin
    imem_req   = (r_state == S_REQ);
    w_redirect = PcSel;
    w_accept   = (r_state == S_REQ)  &&  imem_valid && !Stall && !PcSel;
    w_capture  = (r_state == S_REQ)  &&  imem_valid &&  Stall && !PcSel;
    w_release  = (r_state == S_HOLD) && !Stall && !PcSel;
  end

  // PC, IF/ID and skid buffer. A redirect overrides everything else, so a
  // response in the same cycle is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= '0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
      r_skid       <= NOP;
      r_skid_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc         <= w_target;
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= imem_rdata;
      r_ifid_valid <= 1'b1;
      r_pc         <= w_pc_inc;
    end else if (w_capture) begin
      r_skid       <= imem_rdata;
      r_skid_valid <= 1'b1;
    end else if (w_release) begin
      // The PC has not advanced yet, so it still names the buffered word.
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= r_skid;
      r_ifid_valid <= r_skid_valid;
      r_skid_valid <= 1'b0;
      r_pc         <= w_pc_inc;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misaligned;

  assign w_target   = {BrPC[PC_W-1:2], 2'b00};
  assign w_misalign = PcSel && (BrPC[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misalign;
    end
  end

  assign Misaligned = r_misaligned;
`else
  assign w_target   = BrPC[PC_W-1:0];
  assign Misaligned = 1'b0;
`endif

  assign imem_addr  = r_pc;
  assign IfId_PC    = r_ifid_pc;
  assign IfId_Instr = r_ifid_instr;
  assign IfId_Valid = r_ifid_valid;
  assign Flush      = PcSel;

endmodule

// File: doc/pc_fetch_redirect.md
PC_FETCH_REDIRECT -- requirements
Module: pc_fetch_redirect

Interface
REQ-001 SHALL have parameter: PC_W, default 9, width of the program counter and instruction-memory address.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: PcSel  input  1  redirect request from the branch unit, valid each cycle.
REQ-005 SHALL have port: BrPC  input  32  redirect target; only bits [PC_W-1:0] are used.
REQ-006 SHALL have port: Stall  input  1  hazard stall; IF/ID register holds while high.
REQ-007 SHALL have port: imem_req  output  1  instruction fetch request, level, held until imem_valid.
REQ-008 SHALL have port: imem_addr  output  PC_W  fetch address, equal to the PC register, stable while imem_req=1.
REQ-009 SHALL have port: imem_valid  input  1  one-cycle response strobe, earliest one cycle after imem_req rises.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-011 SHALL have ports: IfId_PC  output  PC_W; IfId_Instr  output  32; IfId_Valid  output  1: the IF/ID pipeline register.
REQ-012 SHALL have port: Flush  output  1  combinational squash of IF/ID and ID/EX, equal to PcSel.
REQ-013 SHALL have port: Misaligned  output  1  one-cycle registered pulse for a misaligned redirect target.

Function
REQ-014 SHALL implement states IDLE, REQ, HOLD, SQUASH; IDLE goes to REQ unconditionally on the first clock after reset.
REQ-015 SHALL drive imem_req=1 in REQ only; imem_req=0 in IDLE, HOLD, SQUASH.
REQ-016 SHALL, in REQ with imem_valid=1, Stall=0, PcSel=0: load IfId_PC<=PC, IfId_Instr<=imem_rdata, IfId_Valid<=1, PC<=PC+4 modulo 2^PC_W, and stay in REQ.
REQ-017 SHALL, in REQ with imem_valid=1, Stall=1, PcSel=0: capture imem_rdata into a one-entry skid buffer, hold IF/ID, and go to HOLD.
REQ-018 SHALL, in HOLD with Stall=0 and PcSel=0: move the skid buffer into IF/ID (IfId_PC<=PC), set PC<=PC+4, and go to REQ.
REQ-019 SHALL hold IF/ID, PC and state unchanged while Stall=1 and PcSel=0, except as in REQ-017.
REQ-020 SHALL give PcSel priority over Stall and imem_valid: PC<=target, IfId_Valid<=0, IfId_Instr<=32'h00000013, skid buffer invalidated.
REQ-021 SHALL, on PcSel=1, go to SQUASH if in REQ with imem_valid=0 or already in SQUASH with imem_valid=0; otherwise go to REQ (any same-cycle response is discarded).
REQ-022 SHALL, in SQUASH with imem_valid=1 and PcSel=0, discard the response and go to REQ.
REQ-023 SHALL never write a discarded or squashed response into IF/ID or the skid buffer.

Reset
REQ-024 SHALL, while reset=0: state=IDLE, PC=0, imem_req=0, IfId_PC=0, IfId_Instr=32'h00000013, IfId_Valid=0, Misaligned=0, skid buffer empty.
REQ-025 SHALL, on reset asserted mid-request, abandon the outstanding request; a late imem_valid after release in IDLE SHALL be ignored.

Configuration
REQ-026 SHALL, with MISALIGN_CHECK_EN defined, load PC with {BrPC[PC_W-1:2],2'b00} and pulse Misaligned for one cycle after any PcSel=1 where BrPC[1:0]!=0.
REQ-027 SHALL, without MISALIGN_CHECK_EN, load PC with BrPC[PC_W-1:0] unmodified and tie Misaligned to 0.

Verification
REQ-028 SHALL cover reset release with 1-cycle memory -> first imem_addr=0, IfId_PC sequence 0,4,8, IfId_Valid=1 from first response.
REQ-029 SHALL cover PC=0x1FC, response accepted -> IfId_PC=0x1FC, next imem_addr=0x000 (wrap, PC_W=9).
REQ-030 SHALL cover PcSel=1, BrPC=0x40 while request for 0x10 outstanding (3-cycle latency) -> Flush=1 that cycle, SQUASH, 0x10 data dropped, next imem_addr=0x40.
REQ-031 SHALL cover response 0xDEADBEEF arriving with Stall=1 for 3 cycles -> IF/ID unchanged during stall, IfId_Instr=0xDEADBEEF the cycle after Stall falls.
REQ-032 SHALL cover PcSel=1 and Stall=1 and imem_valid=1 together, BrPC=0x80 -> IfId_Valid=0, IfId_Instr=0x00000013, next imem_addr=0x80.
REQ-033 SHALL cover BrPC=0x42 with MISALIGN_CHECK_EN -> imem_addr=0x40, Misaligned=1 one cycle; without it -> imem_addr=0x42, Misaligned=0.
